// File: rtl/vmx_result_collector.sv
// -----------------------------------------------------------------------------
// vmx_result_collector
//
// Collects the skewed per-lane accumulator results leaving the VMX systolic
// wrapper and turns them into whole rows for the result BRAM. Lane k of a row
// arrives k cycles after lane 0. The collector delays each lane so that all
// lanes line up, then writes PE_SIZE rows to base_addr..base_addr+PE_SIZE-1.
// After the last row it pulses done for one cycle. Latency is fixed at
// PE_SIZE cycles from a lane-0 beat to its write. There is no backpressure.
//
// Optional build macro:
//   VMX_RESULT_SAT_EN - each lane is saturated to the signed PORT_WIDTH range
//                       and sign-extended back to 2*PORT_WIDTH in the wdata
//                       register stage. Leave it undefined to get raw values.
//
// Ports:
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   start      in   job start pulse, only honoured in IDLE
//   base_addr  in   first write address, latched on an accepted start
//   col_valid  in   lane-0 beat of a new result row is on col_data
//   col_data   in   skewed results, lane k at [k*2*PORT_WIDTH +: 2*PORT_WIDTH]
//   waddr      out  BRAM write address (base + rows written, wraps)
//   wdata      out  deskewed row, same lane layout as col_data
//   wr_en      out  BRAM write strobe, one cycle per row
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last row is written
//   overrun    out  sticky flag: a beat arrived in DRAIN
// -----------------------------------------------------------------------------
module vmx_result_collector #(
    parameter int PE_SIZE    = 4,
    parameter int PORT_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic                            col_valid,
    input  logic [PE_SIZE*2*PORT_WIDTH-1:0] col_data,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [PE_SIZE*2*PORT_WIDTH-1:0] wdata,
    output logic                            wr_en,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun
);

    localparam int LW = 2 * PORT_WIDTH;            // width of one result lane
    localparam int DW = PE_SIZE * LW;              // width of one full row
    localparam int CW = $clog2(PE_SIZE) + 1;       // row counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAPT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         rows_in_q, rows_in_d;
    logic [CW-1:0]         rows_out_q, rows_out_d;
    logic                  overrun_q, overrun_d;

    logic [PE_SIZE-2:0]    vld_q;        // valid line, one stage per lane-0 delay reg
    logic                  row_valid;    // aligned-row valid at the end of the valid line
    logic [DW-1:0]         aligned;      // all lanes of one row, same cycle
    logic [DW-1:0]         wdata_d;      // aligned row after optional saturation
    logic [DW-1:0]         wdata_q;
    logic                  wr_en_q;

    logic                  start_acc;
    logic                  beat_acc;

    assign start_acc = (state_q == S_IDLE) && start;
    // Only beats that belong to the current job enter the valid line; the data
    // path itself is never gated.
    assign beat_acc  = (state_q == S_CAPT) && col_valid && (rows_in_q < CW'(PE_SIZE));

`ifdef VMX_RESULT_SAT_EN
    // A lane fits in signed PORT_WIDTH when its top PORT_WIDTH+1 bits are all
    // equal (pure sign extension); otherwise clamp toward the sign.
    function automatic logic [LW-1:0] sat_lane(input logic [LW-1:0] v);
        logic [PORT_WIDTH:0] top;
        top = v[LW-1:PORT_WIDTH-1];
        if ((top == '0) || (top == '1)) begin
            return v;
        end else if (v[LW-1]) begin
            return {{(PORT_WIDTH+1){1'b1}}, {(PORT_WIDTH-1){1'b0}}};
        end else begin
            return {{(PORT_WIDTH+1){1'b0}}, {(PORT_WIDTH-1){1'b1}}};
        end
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Deskew: lane k trails lane 0 by k cycles, so it is delayed by
    // PE_SIZE-1-k registers. The last lane arrives already aligned.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PE_SIZE; gi++) begin : g_lane
            localparam int DEPTH = PE_SIZE - 1 - gi;

            if (DEPTH == 0) begin : g_pass
                assign aligned[gi*LW +: LW] = col_data[gi*LW +: LW];
            end else begin : g_dly
                logic [LW-1:0] dly_q [DEPTH];

                always_ff @(posedge clk or negedge n_rst) begin
                    if (!n_rst) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            dly_q[i] <= '0;
                        end
                    end else begin
                        dly_q[0] <= col_data[gi*LW +: LW];
                        for (int i = 1; i < DEPTH; i++) begin
                            dly_q[i] <= dly_q[i-1];
                        end
                    end
                end

                assign aligned[gi*LW +: LW] = dly_q[DEPTH-1];
            end

`ifdef VMX_RESULT_SAT_EN
            assign wdata_d[gi*LW +: LW] = sat_lane(aligned[gi*LW +: LW]);
`else
            assign wdata_d[gi*LW +: LW] = aligned[gi*LW +: LW];
`endif
        end
    endgenerate

    assign row_valid = vld_q[PE_SIZE-2];

    // Valid line plus the final row register feeding the BRAM port.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q   <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
        end else begin
            vld_q[0] <= beat_acc;
            for (int i = 1; i < PE_SIZE - 1; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            wdata_q <= wdata_d;
            wr_en_q <= row_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and job counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rows_in_q  <= rows_in_d;
            rows_out_q <= rows_out_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rows_in_d  = rows_in_q;
        rows_out_d = rows_out_q + CW'(wr_en_q);
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    state_d    = S_CAPT;
                    base_d     = base_addr;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            S_CAPT: begin
                if (beat_acc) begin
                    rows_in_d = rows_in_q + CW'(1);
                    if (rows_in_q == CW'(PE_SIZE - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (col_valid) begin
                    overrun_d = 1'b1;
                end
                // Leave on the cycle after the final write, when rows_out
                // becomes PE_SIZE.
                if (wr_en_q && (rows_out_q == CW'(PE_SIZE - 1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address wraps naturally at 2^ADDR_WIDTH.
    assign waddr   = base_q + ADDR_WIDTH'(rows_out_q);
    assign wdata   = wdata_q;
    assign wr_en   = wr_en_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_vmx_result_collector.sv
module tb_vmx_result_collector;

    localparam int PE = 4;
    localparam int PW = 16;
    localparam int AW = 10;
    localparam int LW = 2 * PW;
    localparam int DW = PE * LW;

    logic          clk       = 1'b0;
    logic          n_rst     = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          col_valid = 1'b0;
    logic [DW-1:0] col_data  = '0;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic          overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t wq[$];                 // expected writes, in order
    int  dq[$];                 // expected done cycles
    bit            vsched[int]; // col_valid high in cycle
    logic [AW-1:0] ssched[int]; // start pulse (with base) in cycle
    logic [LW-1:0] dsched[int]; // lane value, key = cycle*PE + lane
    bit            exp_busy[int];
    bit            exp_ovr[int];
    bit            model_ovr = 1'b0;

    logic [LW-1:0] satv [PE] = '{32'h0001_2345, 32'hFFFF_0000, 32'h0000_7FFF, 32'hFFFF_8000};

    vmx_result_collector #(.PE_SIZE(PE), .PORT_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .base_addr (base_addr),
        .col_valid (col_valid),
        .col_data  (col_data),
        .waddr     (waddr),
        .wdata     (wdata),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Expected lane value as the BRAM should see it.
    function automatic logic [LW-1:0] model_lane(input logic [LW-1:0] v);
`ifdef VMX_RESULT_SAT_EN
        int sv;
        sv = $signed(v);
        if (sv > 32767)  return 32'h0000_7FFF;
        if (sv < -32768) return 32'hFFFF_8000;
        return v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Driver: owns start/base_addr/col_valid/col_data, plays back the schedule.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        col_valid = vsched.exists(cyc);
        if (ssched.exists(cyc)) begin
            start     = 1'b1;
            base_addr = ssched[cyc];
        end else begin
            start     = 1'b0;
            base_addr = AW'($urandom);
        end
        for (int k = 0; k < PE; k++) begin
            if (dsched.exists(cyc * PE + k)) col_data[k*LW +: LW] = dsched[cyc * PE + k];
            else                             col_data[k*LW +: LW] = $urandom;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard at mid-cycle.
    always @(negedge clk) begin
        wr_t e;
        if (!n_rst) begin
            check("rst_waddr",   DW'(waddr), '0);
            check("rst_wdata",   wdata,      '0);
            check("rst_wr_en",   DW'(wr_en), '0);
            check("rst_busy",    DW'(busy),  '0);
            check("rst_done",    DW'(done),  '0);
            check("rst_overrun", DW'(overrun), '0);
        end else begin
            while (wq.size() > 0 && wq[0].c < cyc) begin
                checks++; failures++;
                $display("FAIL missed_write cyc=%0d actual=none required=addr %h at cyc %0d", cyc, wq[0].a, wq[0].c);
                void'(wq.pop_front());
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
                checks++; failures++;
                $display("FAIL missed_done cyc=%0d actual=none required=done at cyc %0d", cyc, dq[0]);
                void'(dq.pop_front());
            end
            if (wr_en) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stray_write cyc=%0d actual=wr_en addr %h required=no write", cyc, waddr);
                end else begin
                    e = wq.pop_front();
                    check("wr_cycle", DW'(cyc), DW'(e.c));
                    check("waddr", DW'(waddr), DW'(e.a));
                    check("wdata", wdata, e.d);
                    $display("write cyc=%0d addr=%h data=%h", cyc, waddr, wdata);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stray_done cyc=%0d actual=done required=no done", cyc);
                end else begin
                    check("done_cycle", DW'(cyc), DW'(dq.pop_front()));
                end
            end
            if (exp_busy.exists(cyc)) begin
                check("busy", DW'(busy), DW'(exp_busy[cyc]));
                exp_busy.delete(cyc);
            end
            if (exp_ovr.exists(cyc)) begin
                check("overrun", DW'(overrun), DW'(exp_ovr[cyc]));
                exp_ovr.delete(cyc);
            end
        end
    end

    // One job: schedule start, four skewed rows and any illegal extras, then
    // record the expected writes, done pulse, busy and overrun per cycle.
    // mode: 0 random lanes, 1 lane = {row,lane}, 2 saturation vectors.
    // xstart: 0 none, 1 extra start mid-job, 2 extra start on the done cycle.
    task automatic run_job(input logic [AW-1:0] base, input int gmin, input int gmax,
                           input int mode, input bit pre_beat, input bit ovr_beat,
                           input int xstart, input bit abort);
        int            s, prev, done_c;
        int            t [PE];
        logic [LW-1:0] v;
        logic [DW-1:0] row;
        s = cyc + 2;
        if (pre_beat) begin
            vsched[s-1] = 1'b1;   // beat while IDLE
            vsched[s]   = 1'b1;   // beat on the start cycle
        end
        ssched[s] = base;
        prev = s;
        for (int r = 0; r < PE; r++) begin
            t[r] = prev + 1 + int'($urandom_range(gmax, gmin));
            prev = t[r];
            vsched[t[r]] = 1'b1;
            row = '0;
            for (int k = 0; k < PE; k++) begin
                case (mode)
                    1:       v = {16'(r), 16'(k)};
                    2:       v = satv[k];
                    default: v = $urandom;
                endcase
                dsched[(t[r] + k) * PE + k] = v;
                row[k*LW +: LW] = model_lane(v);
            end
            if (!abort) wq.push_back('{t[r] + PE, base + AW'(r), row});
        end
        done_c = t[PE-1] + PE + 1;
        if (ovr_beat)         vsched[t[PE-1] + 1] = 1'b1;
        if (xstart == 1)      ssched[t[1]]  = ~base;
        else if (xstart == 2) ssched[done_c] = ~base;

        if (!abort) begin
            dq.push_back(done_c);
            exp_busy[s] = 1'b0;
            for (int c = s + 1; c <= done_c; c++) exp_busy[c] = 1'b1;
            exp_busy[done_c + 1] = 1'b0;
            exp_ovr[s] = model_ovr;
            for (int c = s + 1; c <= done_c + 1; c++) exp_ovr[c] = ovr_beat && (c >= t[PE-1] + 2);
            model_ovr = ovr_beat;
            while (cyc < done_c + 2) @(negedge clk);
            check("job_drained", DW'(wq.size() + dq.size()), '0);
        end else begin
            while (cyc < t[1] + 1) @(negedge clk);
            #2 n_rst = 1'b0;
            repeat (3) @(negedge clk);
            #2 n_rst = 1'b1;
            model_ovr = 1'b0;
            while (cyc < t[PE-1] + 8) @(negedge clk);
        end
    endtask

    initial begin
        #2 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_job(10'h010, 0, 0, 1, 1'b0, 1'b0, 0, 1'b0);  // basic job
        run_job(10'h040, 3, 3, 1, 1'b0, 1'b0, 0, 1'b0);  // gapped input
        run_job(10'h3FE, 0, 2, 0, 1'b1, 1'b0, 1, 1'b0);  // wrap + illegal handshakes
        run_job(10'h100, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0);  // overrun
        run_job(10'h200, 0, 1, 2, 1'b0, 1'b0, 2, 1'b0);  // saturation vectors, overrun clears
        run_job(10'h010, 0, 0, 1, 1'b0, 1'b0, 0, 1'b1);  // reset mid-job
        run_job(10'h010, 0, 0, 1, 1'b0, 1'b0, 0, 1'b0);  // re-run of the basic job
        for (int j = 0; j < 10; j++) begin
            run_job(AW'($urandom), 0, 3, 0, 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=still running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
